pipe_control_unit: RTL

//  Pipelined successor to the single-cycle opcode decoder. Decodes the ID-stage opcode into
//  EX/MEM/WB control bundles, carries them through ID/EX, EX/MEM and MEM/WB registers, detects

---
 rtl/pipe_control_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pipe_control_unit.sv
// Pipelined control: decodes the ID opcode and carries EX/MEM/WB control through
// the ID/EX, EX/MEM and MEM/WB registers, with load-use stall and branch flush.
module pipe_control_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int ALUOP_W     = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    input  logic [6:0]             Op_i,
    input  logic [REG_ADDR_W-1:0]  rs1_i,
    input  logic [REG_ADDR_W-1:0]  rs2_i,
    input  logic [REG_ADDR_W-1:0]  rd_i,
    input  logic                   flush_i,
    output logic                   stall_o,
    output logic [ALUOP_W-1:0]     ex_ALUOp_o,
    output logic                   ex_ALUSrc_o,
    output logic [REG_ADDR_W-1:0]  ex_rd_o,
    output logic                   mem_MemRead_o,
    output logic                   mem_MemWrite_o,
    output logic [REG_ADDR_W-1:0]  mem_rd_o,
    output logic                   wb_RegWrite_o,
    output logic                   wb_MemToReg_o,
    output logic [REG_ADDR_W-1:0]  wb_rd_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    typedef struct packed {
        logic [ALUOP_W-1:0]    alu_op;
        logic                  alu_src;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_read;
        logic                  mem_write;
        logic [REG_ADDR_W-1:0] rd;
    } id_ex_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_read;
        logic                  mem_write;
        logic [REG_ADDR_W-1:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [REG_ADDR_W-1:0] rd;
    } mem_wb_t;

    id_ex_t  dec;
    id_ex_t  id_ex_d, id_ex_q;
    ex_mem_t ex_mem_d, ex_mem_q;
    mem_wb_t mem_wb_d, mem_wb_q;
    logic    uses_rs1, uses_rs2;
    logic    hit_rs1, hit_rs2;
    logic [STALL_CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        dec      = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (Op_i)
            OP_R: begin
                dec.reg_write = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_I: begin
                dec.alu_op    = ALUOP_W'(2'b01);
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                uses_rs1      = 1'b1;
            end
            OP_LOAD: begin
                dec.alu_op     = ALUOP_W'(2'b10);
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.mem_read   = 1'b1;
                uses_rs1       = 1'b1;
            end
            OP_STORE: begin
                dec.alu_op    = ALUOP_W'(2'b10);
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_BR: begin
                dec.alu_op = ALUOP_W'(2'b11);
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            default: ;
        endcase
        // Non-writing instructions carry rd=0 so nothing downstream can match it.
        dec.rd = dec.reg_write ? rd_i : '0;
    end

    assign hit_rs1 = uses_rs1 && (id_ex_q.rd == rs1_i);
    assign hit_rs2 = uses_rs2 && (id_ex_q.rd == rs2_i);
    assign stall_o = id_ex_q.mem_read && (id_ex_q.rd != '0) && valid_i
                     && (hit_rs1 || hit_rs2);

    always_comb begin
        id_ex_d = (flush_i || stall_o || !valid_i) ? '0 : dec;

        ex_mem_d.reg_write  = id_ex_q.reg_write;
        ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
        ex_mem_d.mem_read   = id_ex_q.mem_read;
        ex_mem_d.mem_write  = id_ex_q.mem_write;
        ex_mem_d.rd         = id_ex_q.rd;

        mem_wb_d.reg_write  = ex_mem_q.reg_write;
        mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
        mem_wb_d.rd         = ex_mem_q.rd;

        cnt_d = cnt_q;
        if (stall_o && !flush_i && !(&cnt_q)) begin
            cnt_d = cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
            cnt_q    <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ex_ALUOp_o     = id_ex_q.alu_op;
    assign ex_ALUSrc_o    = id_ex_q.alu_src;
    assign ex_rd_o        = id_ex_q.rd;
    assign mem_MemRead_o  = ex_mem_q.mem_read;
    assign mem_MemWrite_o = ex_mem_q.mem_write;
    assign mem_rd_o       = ex_mem_q.rd;
    assign wb_RegWrite_o  = mem_wb_q.reg_write;
    assign wb_MemToReg_o  = mem_wb_q.mem_to_reg;
    assign wb_rd_o        = mem_wb_q.rd;
    assign stall_cnt_o    = cnt_q;

endmodule
